ram_table_loader: RTL and testbench

Downstream consumer of the USB3 receive cache. Takes the cache read data and its 24-lane one-hot write-enable stream, and turns them into addressed writes to 24 destination lookup tables. Lanes 0-7 are the C/A code tables, lanes 8-15 the short parameter tables, and lanes 16-23 the variable-length waveform tables. The block keeps a per-lane write address, checks burst completeness, and publishes a per-table "loaded" bitmap to the DA playback logic.

---
 rtl/ram_table_loader_if.sv | 26 ++
 rtl/ram_table_loader.sv | 218 +++++++++++++++++++++
 tb/tb_ram_table_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_table_loader_if.sv
// Cache-read-side bundle into the table loader and the table write/status bus out of it.
interface ram_table_loader_if #(
  parameter int ADDR_W = 8
);
  logic [31:0]       q;
  logic [23:0]       wren_in;
  logic              tbl_we;
  logic [4:0]        tbl_sel;
  logic [ADDR_W-1:0] tbl_addr;
  logic [31:0]       tbl_data;
  logic [23:0]       tbl_valid;
  logic              burst_done;
  logic              burst_err;
  logic [7:0]        err_count;

  // No backpressure: a nonzero wren_in qualifies q every cycle; tbl_we qualifies the table write.
  modport master (
    output q, wren_in,
    input  tbl_we, tbl_sel, tbl_addr, tbl_data, tbl_valid, burst_done, burst_err, err_count
  );

  modport slave (
    input  q, wren_in,
    output tbl_we, tbl_sel, tbl_addr, tbl_data, tbl_valid, burst_done, burst_err, err_count
  );
endinterface

// File: rtl/ram_table_loader.sv
// Turns the cache's one-hot lane stream into addressed writes to 24 lookup tables,
// checks burst completeness per lane group and publishes a per-table loaded bitmap.
module ram_table_loader #(
  parameter int ADDR_W = 8,
  parameter int LEN_A  = 32,
  parameter int LEN_B  = 10
) (
  input  logic              rdclock,
  input  logic              rst,
  ram_table_loader_if.slave bus,
  output logic [1:0]        fsm_state
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LIM_A = CW'(LEN_A);
  localparam logic [CW-1:0] LIM_B = CW'(LEN_B);
  localparam logic [CW-1:0] LIM_C = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, CLOSE = 2'd2} state_t;

  function automatic logic [1:0] grp_of(input logic [4:0] lane);
    if (lane < 5'd8) return 2'd0;
    else if (lane < 5'd16) return 2'd1;
    else return 2'd2;
  endfunction

  function automatic logic [CW-1:0] lim_of(input logic [1:0] g);
    case (g)
      2'd0:    return LIM_A;
      2'd1:    return LIM_B;
      default: return LIM_C;
    endcase
  endfunction

  function automatic logic [23:0] place(input logic [7:0] b, input logic [1:0] g);
    case (g)
      2'd0:    return {16'h0, b};
      2'd1:    return {8'h0, b, 8'h0};
      default: return {b, 16'h0};
    endcase
  endfunction

  // Stage 1: raw capture
  logic [31:0] s1_q;
  logic [23:0] s1_wren;

  always_ff @(posedge rdclock) begin
    if (rst) begin
      s1_q    <= '0;
      s1_wren <= '0;
    end else begin
      s1_q    <= bus.q;
      s1_wren <= bus.wren_in;
    end
  end

  logic       d_one, d_multi;
  logic [4:0] d_lane;

  always_comb begin
    d_lane = '0;
    for (int i = 0; i < 24; i++) begin
      if (s1_wren[i]) d_lane = 5'(i);
    end
    d_multi = (s1_wren & (s1_wren - 24'd1)) != 24'd0;
    d_one   = (s1_wren != 24'd0) && !d_multi;
  end

  // Stage 2: decoded word feeding the FSM
  logic [31:0] s2_q;
  logic        s2_one, s2_multi;
  logic [4:0]  s2_lane;

  always_ff @(posedge rdclock) begin
    if (rst) begin
      s2_q     <= '0;
      s2_one   <= 1'b0;
      s2_multi <= 1'b0;
      s2_lane  <= '0;
    end else begin
      s2_q     <= s1_q;
      s2_one   <= d_one;
      s2_multi <= d_multi;
      s2_lane  <= d_lane;
    end
  end

  logic          s2_idle;
  logic [1:0]    s2_grp;
  state_t        state, state_next;
  logic [1:0]    grp;
  logic          err;
  logic [CW-1:0] cnt [24];

  assign s2_idle = !s2_one && !s2_multi;
  assign s2_grp  = grp_of(s2_lane);

  logic do_start, do_write, do_fault, do_close, do_drop;

  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_write   = 1'b0;
    do_fault   = 1'b0;
    do_close   = 1'b0;
    do_drop    = 1'b0;
    case (state)
      IDLE: begin
        if (s2_one) begin
          do_start   = 1'b1;
          state_next = BURST;
        end else if (s2_multi) begin
          do_drop = 1'b1;
        end
      end
      BURST: begin
        if (s2_idle) state_next = CLOSE;
        else if (s2_one && s2_grp == grp && cnt[s2_lane] < lim_of(grp)) do_write = 1'b1;
        else do_fault = 1'b1;
      end
      CLOSE: begin
        do_close   = 1'b1;
        state_next = IDLE;
        if (!s2_idle) do_drop = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Completeness of the latched group, evaluated during CLOSE
  logic [7:0] close_bits;
  logic       close_bad;

  always_comb begin
    close_bits = '0;
    close_bad  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (grp == 2'd2) begin
        close_bits[i] = cnt[{grp, 3'b000} + 5'(i)] != '0;
      end else begin
        close_bits[i] = cnt[{grp, 3'b000} + 5'(i)] == lim_of(grp);
        if (!close_bits[i]) close_bad = 1'b1;
      end
    end
  end

  logic [1:0] err_inc;
  logic [8:0] err_sum;
  assign err_inc = {1'b0, do_drop} + {1'b0, do_close & (err | close_bad)};

  logic              we_r, done_r, berr_r;
  logic [4:0]        sel_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       data_r;
  logic [23:0]       valid_r;
  logic [7:0]        errcnt_r;

  assign err_sum = {1'b0, errcnt_r} + 9'(err_inc);

  always_ff @(posedge rdclock) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge rdclock) begin
    if (rst) begin
      we_r     <= 1'b0;
      sel_r    <= '0;
      addr_r   <= '0;
      data_r   <= '0;
      valid_r  <= '0;
      done_r   <= 1'b0;
      berr_r   <= 1'b0;
      errcnt_r <= '0;
      grp      <= '0;
      err      <= 1'b0;
      for (int i = 0; i < 24; i++) cnt[i] <= '0;
    end else begin
      we_r   <= 1'b0;
      done_r <= 1'b0;
      berr_r <= 1'b0;
      errcnt_r <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
      if (do_start) begin
        grp <= s2_grp;
        err <= 1'b0;
        for (int i = 0; i < 8; i++) cnt[{s2_grp, 3'b000} + 5'(i)] <= '0;
        cnt[s2_lane] <= CW'(1);
        valid_r <= valid_r & ~place(8'hFF, s2_grp);
        we_r    <= 1'b1;
        sel_r   <= s2_lane;
        addr_r  <= '0;
        data_r  <= s2_q;
      end
      if (do_write) begin
        cnt[s2_lane] <= cnt[s2_lane] + CW'(1);
        we_r   <= 1'b1;
        sel_r  <= s2_lane;
        addr_r <= cnt[s2_lane][ADDR_W-1:0];
        data_r <= s2_q;
      end
      if (do_fault) err <= 1'b1;
      if (do_close) begin
        valid_r <= (valid_r & ~place(8'hFF, grp)) | place(close_bits, grp);
        done_r  <= 1'b1;
        berr_r  <= err | close_bad;
      end
    end
  end

  assign bus.tbl_we     = we_r;
  assign bus.tbl_sel    = sel_r;
  assign bus.tbl_addr   = addr_r;
  assign bus.tbl_data   = data_r;
  assign bus.tbl_valid  = valid_r;
  assign bus.burst_done = done_r;
  assign bus.burst_err  = berr_r;
  assign bus.err_count  = errcnt_r;
  assign fsm_state      = state;
endmodule

// File: tb/tb_ram_table_loader.sv
// Directed bench for ram_table_loader: table of burst vectors plus hand-written
// sequences for reset mid-burst, idle multi-hot drops and err_count saturation.
module tb_ram_table_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fsm_state;
  int         cyc = 0;

  ram_table_loader_if #(.ADDR_W(8)) bus ();

  ram_table_loader #(.ADDR_W(8), .LEN_A(32), .LEN_B(10)) dut (
    .rdclock   (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: expected {sel, addr, data}
  logic [44:0] exp_q[$];
  int          done_cnt, errp_cnt, done_cyc, first_we_cyc;
  logic [23:0] valid_at_done;

  always @(negedge clk) begin
    if (bus.tbl_we === 1'b1) begin
      if (first_we_cyc < 0) first_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL write_unexpected: got sel=%0d addr=%0d data=0x%0h expected no write",
                 bus.tbl_sel, bus.tbl_addr, bus.tbl_data);
      end else begin
        check("write", 64'({bus.tbl_sel, bus.tbl_addr, bus.tbl_data}), 64'(exp_q.pop_front()));
      end
    end
    if (bus.burst_done === 1'b1) begin
      done_cnt++;
      done_cyc      = cyc;
      valid_at_done = bus.tbl_valid;
    end
    if (bus.burst_err === 1'b1) errp_cnt++;
  end

  task automatic send(input logic [23:0] w, input logic [31:0] d);
    @(negedge clk);
    bus.wren_in = w;
    bus.q       = d;
  endtask

  typedef struct {
    int          first_lane;
    int          n_lanes;
    int          words;
    int          short_lane;
    int          short_words;
    bit          inject;
    logic [23:0] exp_valid;
    int          exp_err_pulses;
    logic [7:0]  exp_err_count;
  } vec_t;

  function automatic int lim_of_lane(input int l);
    if (l < 8) return 32;
    else if (l < 16) return 10;
    else return 256;
  endfunction

  task automatic run_burst(input vec_t v, input logic [7:0] tag);
    int start_edge, idle_edge, nw;
    bit first;
    logic [31:0] d;
    done_cnt     = 0;
    errp_cnt     = 0;
    first_we_cyc = -1;
    first        = 1'b1;
    start_edge   = 0;
    for (int l = v.first_lane; l < v.first_lane + v.n_lanes; l++) begin
      nw = (l == v.short_lane) ? v.short_words : v.words;
      for (int k = 0; k < nw; k++) begin
        if (v.inject && l == 3 && k == 5) begin
          send(24'h000100, 32'hDEAD0001);
          send(24'h000003, 32'hDEAD0002);
        end
        d = {8'(l), tag, 16'(k)};
        send(24'h1 << l, d);
        if (first) begin
          start_edge = cyc + 1;
          first      = 1'b0;
        end
        if (k < lim_of_lane(l)) exp_q.push_back({5'(l), 8'(k), d});
      end
    end
    send(24'h0, 32'h0);
    idle_edge = cyc + 1;
    repeat (6) send(24'h0, 32'h0);
    check("first_write_latency", 64'(first_we_cyc - start_edge), 64'd2);
    check("burst_done_count", 64'(done_cnt), 64'd1);
    check("burst_done_latency", 64'(done_cyc - idle_edge), 64'd3);
    check("valid_at_done", 64'(valid_at_done), 64'(v.exp_valid));
    check("tbl_valid", 64'(bus.tbl_valid), 64'(v.exp_valid));
    check("burst_err_count", 64'(errp_cnt), 64'(v.exp_err_pulses));
    check("err_count", 64'(bus.err_count), 64'(v.exp_err_count));
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tbl_we"}, 64'(bus.tbl_we), 64'd0);
    check({tag, "_tbl_sel"}, 64'(bus.tbl_sel), 64'd0);
    check({tag, "_tbl_addr"}, 64'(bus.tbl_addr), 64'd0);
    check({tag, "_tbl_data"}, 64'(bus.tbl_data), 64'd0);
    check({tag, "_tbl_valid"}, 64'(bus.tbl_valid), 64'd0);
    check({tag, "_burst_done"}, 64'(bus.burst_done), 64'd0);
    check({tag, "_burst_err"}, 64'(bus.burst_err), 64'd0);
    check({tag, "_err_count"}, 64'(bus.err_count), 64'd0);
    check({tag, "_fsm_state"}, 64'(fsm_state), 64'd0);
  endtask

  vec_t vecs[5];
  vec_t clean_a;

  initial begin
    vecs[0] = '{0,  8, 32,  -1, 0, 1'b0, 24'h0000FF, 0, 8'd0};  // full group A
    vecs[1] = '{8,  8, 10,  12, 9, 1'b0, 24'h00EFFF, 1, 8'd1};  // group B, lane 12 short
    vecs[2] = '{18, 1, 5,   -1, 0, 1'b0, 24'h04EFFF, 0, 8'd1};  // group C lane 18
    vecs[3] = '{20, 1, 300, -1, 0, 1'b0, 24'h10EFFF, 1, 8'd2};  // group C lane 20 overflow
    vecs[4] = '{0,  8, 32,  -1, 0, 1'b1, 24'h10EFFF, 1, 8'd3};  // A with foreign + multi-hot
    clean_a = '{0,  8, 32,  -1, 0, 1'b0, 24'h0000FF, 0, 8'd0};

    rst         = 1'b1;
    bus.wren_in = '0;
    bus.q       = '0;
    done_cnt     = 0;
    errp_cnt     = 0;
    done_cyc     = 0;
    first_we_cyc = 0;
    valid_at_done = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) run_burst(vecs[v], 8'(v));

    // Multi-hot word while idle: dropped and counted, no burst
    done_cnt = 0;
    send(24'h000003, 32'h12345678);
    repeat (6) send(24'h0, 32'h0);
    check("idle_multihot_err_count", 64'(bus.err_count), 64'd4);
    check("idle_multihot_no_burst", 64'(done_cnt), 64'd0);
    check("idle_multihot_no_write", 64'(exp_q.size()), 64'd0);

    // Reset after 40 writes of a group A load
    for (int k = 0; k < 42; k++) begin
      logic [31:0] d;
      d = {8'(k / 32), 8'hE0, 16'(k % 32)};
      send(24'h1 << (k / 32), d);
      if (k < 40) exp_q.push_back({5'(k / 32), 8'(k % 32), d});
    end
    @(negedge clk);
    rst         = 1'b1;
    bus.wren_in = '0;
    bus.q       = '0;
    @(negedge clk);
    check_reset_outputs("midburst_reset");
    check("midburst_writes_before_reset", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_burst(clean_a, 8'hE1);

    // Saturation: single-word group B bursts are always incomplete
    done_cnt = 0;
    errp_cnt = 0;
    for (int b = 0; b < 260; b++) begin
      logic [31:0] d;
      d = {8'd8, 8'hF0, 16'(b)};
      send(24'h000100, d);
      exp_q.push_back({5'd8, 8'd0, d});
      send(24'h0, 32'h0);
      send(24'h0, 32'h0);
      if (b == 254) begin
        repeat (4) send(24'h0, 32'h0);
        check("err_count_reaches_255", 64'(bus.err_count), 64'd255);
      end
    end
    repeat (6) send(24'h0, 32'h0);
    check("err_count_holds_255", 64'(bus.err_count), 64'd255);
    check("sat_burst_done_count", 64'(done_cnt), 64'd260);
    check("sat_burst_err_count", 64'(errp_cnt), 64'd260);
    check("sat_tbl_valid", 64'(bus.tbl_valid), 64'h0000FF);
    check("sat_writes_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
